// File: rtl/snake_body_tracker_if.sv
// rtl/snake_body_tracker_if.sv - control and detector-facing bundle for the snake body tracker
interface snake_body_tracker_if #(
  parameter int MaxSegs = 128
);
  logic                   start;
  logic                   moveTick;
  logic [1:0]             direction;
  logic                   appleEaten;
  logic                   collision;
  logic [8*MaxSegs-1:0]   snakeLocX;
  logic [9*MaxSegs-1:0]   snakeLocY;
  logic [7:0]             size;
  logic [1:0]             heading;
  logic                   gameOver;

  modport master (
    input  start, moveTick, direction, appleEaten, collision,
    output snakeLocX, snakeLocY, size, heading, gameOver
  );

  modport slave (
    output start, moveTick, direction, appleEaten, collision,
    input  snakeLocX, snakeLocY, size, heading, gameOver
  );
endinterface

// File: rtl/snake_body_tracker.sv
// rtl/snake_body_tracker.sv - snake segment positions, heading, growth and game-over state
module snake_body_tracker #(
  parameter int SegWidth  = 10,
  parameter int SegHeight = 10,
  parameter int MaxSegs   = 128,
  parameter int StartX    = 150,
  parameter int StartY    = 150,
  parameter int StartSize = 4
) (
  input  logic clock,
  input  logic reset,
  snake_body_tracker_if.master bus
);

  typedef enum logic [1:0] {Ready, Run, Dead} stateT;

  stateT      state, stateNext;
  logic [7:0] locX [MaxSegs];
  logic [8:0] locY [MaxSegs];
  logic [7:0] sizeReg;
  logic [1:0] headingReg;
  logic       growPending;
  logic       appleHist;

  logic       stepEn;
  logic       appleRise;
  logic       growNow;
  logic [1:0] headingNext;
  logic [7:0] headXNext;
  logic [8:0] headYNext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= Ready;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      Ready:   if (bus.start) stateNext = Run;
      Run:     if (bus.collision) stateNext = Dead;
      Dead:    stateNext = Dead;
      default: stateNext = Ready;
    endcase
  end

  // A collision cycle is neither a step nor a growth-capture cycle.
  always_comb begin
    stepEn      = (state == Run) && !bus.collision && bus.moveTick;
    appleRise   = (state == Run) && !bus.collision && bus.appleEaten && !appleHist;
    growNow     = growPending || appleRise;
    headingNext = (bus.direction == (headingReg ^ 2'd2)) ? headingReg : bus.direction;
    headXNext   = locX[0];
    headYNext   = locY[0];
    case (headingNext)
      2'd0: headYNext = locY[0] - 9'(SegHeight);
      2'd1: headXNext = locX[0] + 8'(SegWidth);
      2'd2: headYNext = locY[0] + 9'(SegHeight);
      2'd3: headXNext = locX[0] - 8'(SegWidth);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sizeReg     <= 8'(StartSize);
      headingReg  <= 2'd1;
      growPending <= 1'b0;
      appleHist   <= 1'b0;
      for (int i = 0; i < MaxSegs; i++) begin
        if (i < StartSize) begin
          locX[i] <= 8'(StartX - i * SegWidth);
          locY[i] <= 9'(StartY);
        end else begin
          locX[i] <= '0;
          locY[i] <= '0;
        end
      end
    end else begin
      appleHist <= bus.appleEaten;
      if (stepEn) begin
        for (int i = 1; i < MaxSegs; i++) begin
          locX[i] <= locX[i-1];
          locY[i] <= locY[i-1];
        end
        locX[0]    <= headXNext;
        locY[0]    <= headYNext;
        headingReg <= headingNext;
        if (growNow) begin
          if (sizeReg < 8'(MaxSegs)) sizeReg <= sizeReg + 8'd1;
          growPending <= 1'b0;
        end
      end else if (appleRise) begin
        growPending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MaxSegs; g++) begin : gFlat
    assign bus.snakeLocX[8*g +: 8] = locX[g];
    assign bus.snakeLocY[9*g +: 9] = locY[g];
  end

  assign bus.size     = sizeReg;
  assign bus.heading  = headingReg;
  assign bus.gameOver = (state == Dead);

endmodule

// File: tb/tb_snake_body_tracker.sv
// tb/tb_snake_body_tracker.sv - directed checks of snake_body_tracker with hand-computed positions
module tb_snake_body_tracker;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cmpCount = 0;
  int   errCount = 0;

  always #5 clock = ~clock;

  snake_body_tracker_if #(.MaxSegs(128)) ifA ();
  snake_body_tracker_if #(.MaxSegs(8))   ifB ();

  snake_body_tracker dutA (
    .clock (clock),
    .reset (reset),
    .bus   (ifA)
  );

  snake_body_tracker #(
    .MaxSegs(8), .StartX(25), .StartY(150), .StartSize(7)
  ) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (ifB)
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ax(input int i);
    return int'(ifA.snakeLocX[8*i +: 8]);
  endfunction
  function automatic int ay(input int i);
    return int'(ifA.snakeLocY[9*i +: 9]);
  endfunction
  function automatic int bx(input int i);
    return int'(ifB.snakeLocX[8*i +: 8]);
  endfunction

  // Drives one cycle's inputs on a negedge and returns at the next negedge.
  task automatic cycA(input bit tick, input logic [1:0] dir, input bit apple,
                      input bit coll, input bit st);
    ifA.moveTick = tick; ifA.direction = dir; ifA.appleEaten = apple;
    ifA.collision = coll; ifA.start = st;
    @(negedge clock);
    ifA.moveTick = 0; ifA.collision = 0; ifA.start = 0;
  endtask

  task automatic cycB(input bit tick, input logic [1:0] dir, input bit apple, input bit st);
    ifB.moveTick = tick; ifB.direction = dir; ifB.appleEaten = apple; ifB.start = st;
    @(negedge clock);
    ifB.moveTick = 0; ifB.start = 0; ifB.appleEaten = 0;
  endtask

  initial begin
    ifA.start = 0; ifA.moveTick = 0; ifA.direction = 2'd1; ifA.appleEaten = 0; ifA.collision = 0;
    ifB.start = 0; ifB.moveTick = 0; ifB.direction = 2'd1; ifB.appleEaten = 0; ifB.collision = 0;
    reset = 0;
    repeat (2) @(negedge clock);

    checkVal("rst size", ifA.size, 4);
    checkVal("rst heading", ifA.heading, 1);
    checkVal("rst gameOver", ifA.gameOver, 0);
    checkVal("rst head x", ax(0), 150);
    checkVal("rst seg3 x", ax(3), 120);
    checkVal("rst seg3 y", ay(3), 150);
    checkVal("rst seg4 x", ax(4), 0);
    checkVal("rst seg4 y", ay(4), 0);
    reset = 1;
    @(negedge clock);

    cycA(1, 2'd1, 0, 0, 0);
    checkVal("ready tick ignored", ax(0), 150);
    cycA(0, 2'd1, 0, 0, 1);
    for (int k = 0; k < 3; k++) cycA(1, 2'd1, 0, 0, 0);
    checkVal("3tick head x", ax(0), 180);
    checkVal("3tick head y", ay(0), 150);
    checkVal("3tick seg1 x", ax(1), 170);
    checkVal("3tick seg3 x", ax(3), 150);
    checkVal("3tick size", ifA.size, 4);

    cycA(1, 2'd3, 0, 0, 0);
    checkVal("reverse heading", ifA.heading, 1);
    checkVal("reverse head x", ax(0), 190);
    cycA(1, 2'd0, 0, 0, 0);
    checkVal("up head y", ay(0), 140);
    checkVal("up head x", ax(0), 190);
    checkVal("up heading", ifA.heading, 0);
    checkVal("up seg1 y", ay(1), 150);

    for (int k = 0; k < 5; k++) cycA(0, 2'd0, 1, 0, 0);
    cycA(0, 2'd0, 0, 0, 0);
    checkVal("apple no tick size", ifA.size, 4);
    cycA(1, 2'd0, 0, 0, 0);
    checkVal("grow size", ifA.size, 5);
    checkVal("grow seg4 x", ax(4), 170);
    checkVal("grow seg4 y", ay(4), 150);
    checkVal("grow head y", ay(0), 130);
    cycA(1, 2'd0, 0, 0, 0);
    checkVal("held once size", ifA.size, 5);
    checkVal("held once head y", ay(0), 120);

    cycA(1, 2'd0, 1, 0, 0);
    checkVal("same-cycle grow", ifA.size, 6);
    cycA(0, 2'd0, 0, 0, 0);
    cycA(0, 2'd0, 1, 0, 0);
    cycA(0, 2'd0, 0, 0, 0);
    cycA(0, 2'd0, 1, 0, 0);
    cycA(0, 2'd0, 0, 0, 0);
    cycA(1, 2'd1, 0, 0, 0);
    checkVal("no stack size a", ifA.size, 7);
    checkVal("turn right x", ax(0), 200);
    cycA(1, 2'd1, 0, 0, 0);
    checkVal("no stack size b", ifA.size, 7);

    cycA(1, 2'd1, 0, 1, 0);
    checkVal("coll head x", ax(0), 210);
    checkVal("coll head y", ay(0), 110);
    checkVal("coll gameOver", ifA.gameOver, 1);
    cycA(1, 2'd1, 0, 0, 0);
    cycA(0, 2'd1, 0, 0, 1);
    cycA(1, 2'd2, 1, 0, 0);
    cycA(1, 2'd2, 0, 0, 0);
    checkVal("dead frozen x", ax(0), 210);
    checkVal("dead frozen size", ifA.size, 7);
    checkVal("dead gameOver", ifA.gameOver, 1);

    reset = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    cycA(0, 2'd1, 0, 0, 1);
    cycA(1, 2'd1, 0, 0, 0);
    checkVal("rerun head x", ax(0), 160);
    #1 reset = 0;
    #1;
    checkVal("async rst head x", ax(0), 150);
    checkVal("async rst gameOver", ifA.gameOver, 0);
    checkVal("async rst size", ifA.size, 4);
    @(negedge clock);
    reset = 1;
    @(negedge clock);

    reset = 0;
    @(negedge clock);
    checkVal("b rst size", ifB.size, 7);
    checkVal("b rst seg3 x", bx(3), 251);
    checkVal("b rst seg6 x", bx(6), 221);
    reset = 1;
    @(negedge clock);
    cycB(0, 2'd1, 0, 1);
    cycB(0, 2'd1, 1, 0);
    cycB(1, 2'd0, 0, 0);
    checkVal("b grow to max", ifB.size, 8);
    checkVal("b seg7 x", bx(7), 221);
    cycB(0, 2'd0, 1, 0);
    cycB(1, 2'd3, 0, 0);
    checkVal("b saturate", ifB.size, 8);
    checkVal("b left x", bx(0), 15);
    cycB(1, 2'd3, 0, 0);
    checkVal("b x five", bx(0), 5);
    cycB(1, 2'd3, 0, 0);
    checkVal("b wrap x", bx(0), 251);
    checkVal("b heading", ifB.heading, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
